// File: rtl/cues_pkg.sv
// Shared token field widths, entry layout and classifier actions.
// Used by the FC0 match stage and its matching memory.
package cues_pkg;

    localparam int NODE_W = 16;
    localparam int GEN_W  = 12;
    localparam int OPR_W  = 32;
    localparam int MWEN_W = 2;

    // mem_wen code meaning "downstream must not write"
    localparam logic [MWEN_W-1:0] MWEN_NONE = 2'b00;

    typedef struct packed {
        logic [NODE_W-1:0] node;
        logic [GEN_W-1:0]  gen;
        logic              lr;
        logic [OPR_W-1:0]  opr;
        logic [MWEN_W-1:0] mem_wen;
    } mm_entry_t;

    typedef enum logic [2:0] {
        ACT_IDLE,
        ACT_MONO,
        ACT_STORE,
        ACT_PAIR,
        ACT_REJ
    } fc0_act_e;

endpackage

// File: rtl/fc0_mm.sv
// FC0 matching memory: register array, async read, sync write/clear.
// Ports: clk, rst, idx, wr_en/wdata, clr_en, flush, rd_vld/rd_data.
module fc0_mm
    import cues_pkg::*;
#(
    parameter int MM_DEPTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(MM_DEPTH)-1:0] idx,
    input  logic                        wr_en,
    input  mm_entry_t                   wdata,
    input  logic                        clr_en,
    input  logic                        flush,
    output logic                        rd_vld,
    output mm_entry_t                   rd_data
);

    logic [MM_DEPTH-1:0] vld_q;
    mm_entry_t           data_q [MM_DEPTH];

    // Only the valid bits need reset; data is qualified by them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else if (wr_en) begin
            vld_q[idx] <= 1'b1;
        end else if (clr_en) begin
            vld_q[idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            data_q[idx] <= wdata;
        end
    end

    assign rd_vld  = vld_q[idx];
    assign rd_data = data_q[idx];

endmodule

// File: rtl/fc0_match.sv
// FC0 token matching stage: pairs dyadic operands by node/gen tag.
// Ports: token in (vld/mono/lr/node/gen/opr/mem_wen), flush, fired/rejected token out, occ.
module fc0_match
    import cues_pkg::*;
#(
    parameter int MM_DEPTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        vld_i,
    input  logic                        mono_i,
    input  logic                        lr_i,
    input  logic [NODE_W-1:0]           node_i,
    input  logic [GEN_W-1:0]            gen_i,
    input  logic [OPR_W-1:0]            opr_i,
    input  logic [MWEN_W-1:0]           mem_wen_i,
    input  logic                        flush_i,
    output logic                        lr_o,
    output logic [NODE_W-1:0]           node_o,
    output logic [GEN_W-1:0]            gen_o,
    output logic [OPR_W-1:0]            opr_o,
    output logic [MWEN_W-1:0]           mem_wen_o,
    output logic [OPR_W-1:0]            mtch_data_o,
    output logic                        fire_o,
    output logic                        rej_vld_o,
    output logic [NODE_W-1:0]           rej_node_o,
    output logic [GEN_W-1:0]            rej_gen_o,
    output logic                        rej_lr_o,
    output logic [OPR_W-1:0]            rej_opr_o,
    output logic [MWEN_W-1:0]           rej_mem_wen_o,
    output logic [$clog2(MM_DEPTH):0]   occ_o
);

    localparam int AW = $clog2(MM_DEPTH);
    localparam logic [AW:0] OCC_ONE = 1;

    fc0_act_e  act;
    logic      rd_vld;
    mm_entry_t rd_data;
    mm_entry_t wdata;
    logic      tag_hit;
    logic      fire;
    logic      rej;
    logic      unused_mm;

    assign wdata = '{
        node:    node_i,
        gen:     gen_i,
        lr:      lr_i,
        opr:     opr_i,
        mem_wen: mem_wen_i
    };

    fc0_mm #(
        .MM_DEPTH(MM_DEPTH)
    ) u_mm (
        .clk    (clk),
        .rst    (rst),
        .idx    (node_i[AW-1:0]),
        .wr_en  (act == ACT_STORE),
        .wdata  (wdata),
        .clr_en (act == ACT_PAIR),
        .flush  (flush_i),
        .rd_vld (rd_vld),
        .rd_data(rd_data)
    );

    // The partner's own mem_wen is superseded by the arriving one.
    assign unused_mm = ^rd_data.mem_wen;

    assign tag_hit = (rd_data.node == node_i) && (rd_data.gen == gen_i);

    // A flush wipes the entry this token would see, so dyadic
    // tokens in a flush cycle cannot be matched and bounce.
    always_comb begin
        act = ACT_IDLE;
        if (vld_i) begin
            if (mono_i) begin
                act = ACT_MONO;
            end else if (flush_i) begin
                act = ACT_REJ;
            end else if (!rd_vld) begin
                act = ACT_STORE;
            end else if (tag_hit && (rd_data.lr != lr_i)) begin
                act = ACT_PAIR;
            end else begin
                act = ACT_REJ;
            end
        end
    end

    assign fire = (act == ACT_MONO) || (act == ACT_PAIR);
    assign rej  = (act == ACT_REJ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_o <= '0;
        end else if (flush_i) begin
            occ_o <= '0;
        end else if (act == ACT_STORE) begin
            occ_o <= occ_o + OCC_ONE;
        end else if (act == ACT_PAIR) begin
            occ_o <= occ_o - OCC_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_o        <= 1'b0;
            rej_vld_o     <= 1'b0;
            lr_o          <= 1'b0;
            node_o        <= '0;
            gen_o         <= '0;
            opr_o         <= '0;
            mem_wen_o     <= MWEN_NONE;
            mtch_data_o   <= '0;
            rej_node_o    <= '0;
            rej_gen_o     <= '0;
            rej_lr_o      <= 1'b0;
            rej_opr_o     <= '0;
            rej_mem_wen_o <= MWEN_NONE;
        end else begin
            fire_o    <= fire;
            rej_vld_o <= rej;
            mem_wen_o <= fire ? mem_wen_i : MWEN_NONE;
            if (fire) begin
                lr_o        <= lr_i;
                node_o      <= node_i;
                gen_o       <= gen_i;
                opr_o       <= opr_i;
                mtch_data_o <= (act == ACT_PAIR) ? rd_data.opr : '0;
            end
            if (rej) begin
                rej_node_o    <= node_i;
                rej_gen_o     <= gen_i;
                rej_lr_o      <= lr_i;
                rej_opr_o     <= opr_i;
                rej_mem_wen_o <= mem_wen_i;
            end
        end
    end

endmodule
